debug_loader: RTL and testbench

Host-side control block that sits directly upstream of the MIPS pipeline top. It receives command and data bytes from the UART receiver and assembles them into 32-bit words. It drives the pipeline's instruction-memory write port (write flag, address, data) and its halt input. It runs the program continuously or one cycle at a time, and reports completion with a single acknowledge byte to the UART transmitter.

---
 rtl/debug_loader.sv | 213 +++++++++++++++++++++
 tb/tb_debug_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_loader.sv
// -----------------------------------------------------------------------------
// debug_loader
//
// Host-side control block that sits in front of the MIPS pipeline. Command and
// data bytes arrive from a UART receiver. Program bytes are assembled MSB-first
// into 32-bit words, which are written into instruction memory. The block also
// runs the pipeline freely or one cycle at a time. Every command that completes
// is acknowledged with one byte to the UART transmitter.
//
// Commands accepted in IDLE:
//   'L' (0x4C) load words until HALT_WORD  -> ack 'K', or 'E' on overflow
//   'C' (0x43) run until i_program_end     -> ack 'D'
//   'S' (0x53) release the pipeline one cycle -> ack 'S'
//   'C'/'S' without a completed load, or after the program has finished,
//   -> ack 'E' and the pipeline stays halted.
//
// Ports:
//   i_clk                   system clock, rising edge
//   i_reset                 synchronous active-high reset
//   i_rx_data / i_rx_valid  received byte and its one-cycle strobe
//   i_tx_busy               transmitter busy; o_tx_start is held off while high
//   i_program_end           pipeline has retired HALT_WORD
//   o_tx_start / o_tx_data  one-cycle send strobe and acknowledge byte
//   o_write_instruction_mem one-cycle instruction-memory write enable
//   o_instruction_mem_addr  word-aligned byte address of the write
//   o_instruction_mem_data  word being written
//   o_halt                  1 = pipeline frozen
// -----------------------------------------------------------------------------
module debug_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_tx_busy,
  input  logic        i_program_end,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  output logic        o_write_instruction_mem,
  output logic [31:0] o_instruction_mem_addr,
  output logic [31:0] o_instruction_mem_data,
  output logic        o_halt
);

  // One extra bit so the word counter can hold MAX_WORDS itself (the full mark).
  localparam int CW = $clog2(MAX_WORDS) + 1;
  localparam logic [CW-1:0] W_MAX = CW'(MAX_WORDS);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] ACK_OK   = 8'h4B;
  localparam logic [7:0] ACK_ERR  = 8'h45;
  localparam logic [7:0] ACK_DONE = 8'h44;
  localparam logic [7:0] ACK_STEP = 8'h53;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RUN, S_STEP, S_ACK
  } state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_asm, w_asm_next;
  logic [1:0]    r_byte_cnt, w_byte_cnt_next;
  logic [CW-1:0] r_word_cnt, w_word_cnt_next;
  logic          r_loaded, w_loaded_next;
  logic          r_finished, w_finished_next;
  logic          r_tx_start, w_tx_start_next;
  logic [7:0]    r_tx_data, w_tx_data_next;
  logic          r_we, w_we_next;
  logic [31:0]   r_addr, w_addr_next;
  logic [31:0]   r_data, w_data_next;
  logic          r_halt, w_halt_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_asm      <= '0;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_loaded   <= 1'b0;
      r_finished <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_halt     <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_asm      <= w_asm_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_word_cnt <= w_word_cnt_next;
      r_loaded   <= w_loaded_next;
      r_finished <= w_finished_next;
      r_tx_start <= w_tx_start_next;
      r_tx_data  <= w_tx_data_next;
      r_we       <= w_we_next;
      r_addr     <= w_addr_next;
      r_data     <= w_data_next;
      r_halt     <= w_halt_next;
    end
  end

  // Outputs are registered: every *_next value is what the port shows during
  // the cycle spent in w_state_next.
  always_comb begin
    w_state_next    = r_state;
    w_asm_next      = r_asm;
    w_byte_cnt_next = r_byte_cnt;
    w_word_cnt_next = r_word_cnt;
    w_loaded_next   = r_loaded;
    w_finished_next = r_finished;
    w_tx_start_next = 1'b0;
    w_tx_data_next  = r_tx_data;
    w_we_next       = 1'b0;
    w_addr_next     = r_addr;
    w_data_next     = r_data;

    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            w_state_next    = S_LOAD;
            w_byte_cnt_next = '0;
            w_word_cnt_next = '0;
            w_loaded_next   = 1'b0;
          end else if (i_rx_data == CMD_CONT || i_rx_data == CMD_STEP) begin
            if (!r_loaded || r_finished) begin
              w_state_next   = S_ACK;
              w_tx_data_next = ACK_ERR;
            end else begin
              w_state_next = (i_rx_data == CMD_CONT) ? S_RUN : S_STEP;
            end
          end
        end
      end

      S_LOAD: begin
        if (i_rx_valid) begin
          w_asm_next      = {r_asm[23:0], i_rx_data};
          w_byte_cnt_next = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            // The write strobe is prepared here so it is visible during the
            // WRITE cycle itself; a full memory suppresses it.
            w_state_next = S_WRITE;
            if (r_word_cnt < W_MAX) begin
              w_we_next   = 1'b1;
              w_addr_next = 32'({r_word_cnt, 2'b00});
              w_data_next = w_asm_next;
            end
          end
        end
      end

      S_WRITE: begin
        if (r_word_cnt < W_MAX) begin
          w_word_cnt_next = r_word_cnt + 1'b1;
          if (r_asm == HALT_WORD) begin
            w_loaded_next   = 1'b1;
            w_finished_next = 1'b0;
            w_state_next    = S_ACK;
            w_tx_data_next  = ACK_OK;
          end else begin
            w_state_next = S_LOAD;
          end
        end else begin
          w_state_next   = S_ACK;
          w_tx_data_next = ACK_ERR;
        end
      end

      S_RUN: begin
        if (i_program_end) begin
          w_finished_next = 1'b1;
          w_state_next    = S_ACK;
          w_tx_data_next  = ACK_DONE;
        end
      end

      S_STEP: begin
        if (i_program_end) begin
          w_finished_next = 1'b1;
        end
        w_state_next   = S_ACK;
        w_tx_data_next = ACK_STEP;
      end

      S_ACK: begin
        if (!i_tx_busy) begin
          w_tx_start_next = 1'b1;
          w_state_next    = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // The pipeline only moves while running or during the single step cycle.
    w_halt_next = !((w_state_next == S_RUN) || (w_state_next == S_STEP));
  end

  assign o_tx_start              = r_tx_start;
  assign o_tx_data               = r_tx_data;
  assign o_write_instruction_mem = r_we;
  assign o_instruction_mem_addr  = r_addr;
  assign o_instruction_mem_data  = r_data;
  assign o_halt                  = r_halt;

endmodule

// File: tb/tb_debug_loader.sv
module tb_debug_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic        program_end = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data;
  logic        halt;

  int n_assert = 0;
  int n_fail = 0;
  int tx_cnt = 0;
  int halt_low_cnt = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  debug_loader #(.MAX_WORDS(4), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .i_clk                   (clk),
    .i_reset                 (rst),
    .i_rx_data               (rx_data),
    .i_rx_valid              (rx_valid),
    .i_tx_busy               (tx_busy),
    .i_program_end           (program_end),
    .o_tx_start              (tx_start),
    .o_tx_data               (tx_data),
    .o_write_instruction_mem (we),
    .o_instruction_mem_addr  (addr),
    .o_instruction_mem_data  (data),
    .o_halt                  (halt)
  );

  always #5 clk = ~clk;

  // Passive monitor on the falling edge: records every write and counts
  // acknowledge strobes and pipeline-running cycles.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(data);
    end
    if (tx_start === 1'b1) tx_cnt++;
    if (halt === 1'b0) halt_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Sends a word MSB first; we_seen is the write strobe in the cycle right
  // after the 4th byte was sampled. One idle cycle covers the WRITE state.
  task automatic send_word(input logic [31:0] w, output logic we_seen);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    we_seen = we;
    tick();
  endtask

  task automatic wait_ack(output logic got, output logic [7:0] b);
    got = 1'b0;
    b   = 8'h00;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_start === 1'b1) begin
        got = 1'b1;
        b   = tx_data;
        break;
      end
    end
  endtask

  initial begin
    logic       we_seen;
    logic       got;
    logic [7:0] ab;
    int         wr0, tx0, hl0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_halt", halt, 1);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    rst = 1'b0;
    tick();

    // Load two words, the second being the terminator
    wr0 = wr_addr_q.size(); tx0 = tx_cnt; hl0 = halt_low_cnt;
    send_byte(8'h4C);
    send_word(32'h0000_0020, we_seen);
    check("load_w0_latency", we_seen, 1);
    send_word(32'hFFFF_FFFF, we_seen);
    check("load_w1_latency", we_seen, 1);
    wait_ack(got, ab);
    check("load_ack_seen", got, 1);
    check("load_ack_byte", ab, 8'h4B);
    tick();
    check("load_write_count", wr_addr_q.size() - wr0, 2);
    check("load_w0_addr", wr_addr_q[wr0], 32'h0);
    check("load_w0_data", wr_data_q[wr0], 32'h0000_0020);
    check("load_w1_addr", wr_addr_q[wr0+1], 32'h4);
    check("load_w1_data", wr_data_q[wr0+1], 32'hFFFF_FFFF);
    check("load_ack_count", tx_cnt - tx0, 1);
    check("load_halt_held", halt_low_cnt - hl0, 0);

    // Continuous run: 10 cycles without program_end, then one pulse
    hl0 = halt_low_cnt;
    send_byte(8'h43);
    check("run_halt_fall", halt, 0);
    repeat (10) tick();
    program_end = 1'b1;
    tick();
    program_end = 1'b0;
    check("run_halt_rise", halt, 1);
    wait_ack(got, ab);
    check("run_ack_seen", got, 1);
    check("run_ack_byte", ab, 8'h44);
    check("run_low_cycles", halt_low_cnt - hl0, 11);

    // Run again after finishing is refused
    hl0 = halt_low_cnt;
    send_byte(8'h43);
    wait_ack(got, ab);
    check("rerun_ack_byte", ab, 8'h45);
    check("rerun_halt_held", halt_low_cnt - hl0, 0);

    // Reload, then three single steps
    send_byte(8'h4C);
    send_word(32'h0000_0020, we_seen);
    send_word(32'hFFFF_FFFF, we_seen);
    wait_ack(got, ab);
    check("reload_ack_byte", ab, 8'h4B);
    for (int k = 0; k < 3; k++) begin
      hl0 = halt_low_cnt;
      send_byte(8'h53);
      check("step_halt_low", halt, 0);
      tick();
      check("step_halt_back", halt, 1);
      wait_ack(got, ab);
      check("step_ack_byte", ab, 8'h53);
      check("step_low_cycles", halt_low_cnt - hl0, 1);
    end

    // Overflow with MAX_WORDS=4: five non-terminator words
    wr0 = wr_addr_q.size();
    send_byte(8'h4C);
    for (int k = 0; k < 5; k++) begin
      send_word(32'h1111_1111 * (k + 1), we_seen);
      check("ovf_write_strobe", we_seen, (k < 4) ? 1 : 0);
    end
    wait_ack(got, ab);
    check("ovf_ack_byte", ab, 8'h45);
    tick();
    check("ovf_write_count", wr_addr_q.size() - wr0, 4);
    for (int k = 0; k < 4; k++) begin
      check("ovf_addr", wr_addr_q[wr0+k], 32'(k * 4));
      check("ovf_data", wr_data_q[wr0+k], 32'h1111_1111 * (k + 1));
    end

    // Transmitter busy while entering ACK ('C' with nothing loaded)
    tx0 = tx_cnt;
    tx_busy = 1'b1;
    send_byte(8'h43);
    repeat (7) tick();
    check("busy_no_start", tx_cnt - tx0, 0);
    check("busy_data_held", tx_data, 8'h45);
    tx_busy = 1'b0;
    tick();
    check("busy_start_after_release", tx_start, 1);
    tick();
    check("busy_start_single", tx_start, 0);
    tick();
    check("busy_start_count", tx_cnt - tx0, 1);

    // Reset in the middle of a word, then a fresh load
    wr0 = wr_addr_q.size();
    send_byte(8'h4C);
    send_byte(8'h12);
    send_byte(8'h34);
    rst = 1'b1;
    tick();
    check("midrst_halt", halt, 1);
    check("midrst_we", we, 0);
    rst = 1'b0;
    tick();
    send_byte(8'h4C);
    send_word(32'hFFFF_FFFF, we_seen);
    wait_ack(got, ab);
    check("midrst_ack_byte", ab, 8'h4B);
    tick();
    check("midrst_write_count", wr_addr_q.size() - wr0, 1);
    check("midrst_addr", wr_addr_q[wr0], 32'h0);
    check("midrst_data", wr_data_q[wr0], 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
